// File: rtl/rpn_pkg.sv
// rpn_pkg: shared states, opcodes and error codes for the RPN evaluator.
// RPN_MUL_EN decides whether opcode 10 counts as a legal operator.
package rpn_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_GET_B, S_GET_A, S_RES_POP, S_RES_CHK, S_DONE, S_FLUSH, S_ERR
  } state_t;
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_RSV = 2'd3;
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_OVF  = 2'd1;
  localparam logic [1:0] ERR_UNF  = 2'd2;
  localparam logic [1:0] ERR_MAL  = 2'd3;
  function automatic logic op_ok(input logic [1:0] op);
`ifdef RPN_MUL_EN
    return op != OP_RSV;
`else
    return op == OP_ADD || op == OP_SUB;
`endif
  endfunction
endpackage

// File: rtl/rpn_alu.sv
// rpn_alu: combinational ADD/SUB(/MUL) modulo 2^WORD_LEN.
// MUL exists only when RPN_MUL_EN is defined.
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int WORD_LEN = 8
) (
  input  logic [1:0]          i_op,
  input  logic [WORD_LEN-1:0] i_a,
  input  logic [WORD_LEN-1:0] i_b,
  output logic [WORD_LEN-1:0] o_y
);
  always_comb begin
`ifdef RPN_MUL_EN
    o_y = i_op == OP_ADD ? i_a + i_b :
          i_op == OP_SUB ? i_a - i_b :
          i_op == OP_MUL ? i_a * i_b : '0;
`else
    o_y = i_op == OP_SUB ? i_a - i_b : i_a + i_b;
`endif
  end
endmodule

// File: rtl/rpn_evaluator.sv
// rpn_evaluator: postfix evaluator driving an external LIFO stack, with error flush.
// Build option RPN_MUL_EN enables opcode 10 (MUL) in rpn_alu.
module rpn_evaluator
  import rpn_pkg::*;
#(
  parameter int WORD_LEN = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                token_valid,
  output logic                token_ready,
  input  logic                token_is_op,
  input  logic                token_last,
  input  logic [WORD_LEN-1:0] token_data,
  output logic                st_push,
  output logic                st_pop,
  output logic [WORD_LEN-1:0] st_data_in,
  input  logic [WORD_LEN-1:0] st_data_out,
  input  logic                st_full,
  input  logic                st_empty,
  output logic [WORD_LEN-1:0] result,
  output logic                result_valid,
  input  logic                result_ready,
  output logic [1:0]          err,
  input  logic                err_clr
);
  state_t              r_state, w_state_nxt;
  logic [1:0]          r_op, r_err, w_err_nxt;
  logic                r_last;
  logic [WORD_LEN-1:0] r_b, r_result, w_alu_y;
  logic                w_acc, w_op_ok;

  assign w_acc   = token_valid && r_state == S_IDLE;
  assign w_op_ok = op_ok(token_data[1:0]);
  assign result  = r_result;
  assign err     = r_err;

  rpn_alu #(.WORD_LEN(WORD_LEN)) u_alu (
    .i_op (r_op),
    .i_a  (st_data_out),
    .i_b  (r_b),
    .o_y  (w_alu_y)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_err    <= ERR_NONE;
      r_op     <= OP_ADD;
      r_last   <= 1'b0;
      r_b      <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_err_nxt;
      if (w_acc) begin
        r_op   <= token_data[1:0];
        r_last <= token_last;
      end
      if (r_state == S_GET_B) r_b <= st_data_out;
      if (r_state == S_RES_CHK) r_result <= st_data_out;
    end
  end

  // every error enters FLUSH; the error code is latched on that transition
  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = r_err;
    case (r_state)
      S_IDLE:
        if (w_acc) begin
          if (!token_is_op) begin
            if (st_full) {w_state_nxt, w_err_nxt} = {S_FLUSH, ERR_OVF};
            else if (token_last) w_state_nxt = S_RES_POP;
          end else if (!w_op_ok) {w_state_nxt, w_err_nxt} = {S_FLUSH, ERR_MAL};
          else if (st_empty) {w_state_nxt, w_err_nxt} = {S_FLUSH, ERR_UNF};
          else w_state_nxt = S_GET_B;
        end
      S_GET_B:   {w_state_nxt, w_err_nxt} = st_empty ? {S_FLUSH, ERR_UNF} : {S_GET_A, r_err};
      S_GET_A:   w_state_nxt = r_last ? S_RES_POP : S_IDLE;
      S_RES_POP: w_state_nxt = S_RES_CHK;
      S_RES_CHK: {w_state_nxt, w_err_nxt} = st_empty ? {S_DONE, r_err} : {S_FLUSH, ERR_MAL};
      S_DONE:    w_state_nxt = result_ready ? S_IDLE : S_DONE;
      S_FLUSH:   w_state_nxt = st_empty ? S_ERR : S_FLUSH;
      S_ERR:     if (err_clr) {w_state_nxt, w_err_nxt} = {S_IDLE, ERR_NONE};
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    token_ready  = r_state == S_IDLE;
    result_valid = r_state == S_DONE;
    st_push      = (w_acc && !token_is_op && !st_full) || r_state == S_GET_A;
    st_pop       = (w_acc && token_is_op && w_op_ok && !st_empty) ||
                   ((r_state == S_GET_B || r_state == S_FLUSH) && !st_empty) ||
                   r_state == S_RES_POP;
    st_data_in   = r_state == S_GET_A ? w_alu_y : token_data;
  end
endmodule

// File: tb/tb_rpn_evaluator.sv
// tb_rpn_evaluator: random and directed RPN expressions against a queue-based model,
// with a behavioural LIFO stack attached to the evaluator.
module tb_rpn_evaluator;
  localparam int DEPTH = 8;
`ifdef RPN_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef struct {
    bit         is_op;
    logic [7:0] d;
  } tok_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       token_valid = 1'b0, token_is_op = 1'b0, token_last = 1'b0;
  logic [7:0] token_data = '0;
  logic       result_ready = 1'b0, err_clr = 1'b0;
  logic       token_ready, st_push, st_pop, st_full, st_empty, result_valid;
  logic [7:0] st_data_in, st_data_out, result;
  logic [1:0] err;

  logic [7:0] mem [DEPTH];
  int         sp;
  int         pushes = 0, pops = 0, bad = 0;
  int         n_chk = 0, n_err = 0;
  tok_t       q[$];

  rpn_evaluator #(.WORD_LEN(8)) dut (
    .clk(clk), .rstn(rstn),
    .token_valid(token_valid), .token_ready(token_ready), .token_is_op(token_is_op),
    .token_last(token_last), .token_data(token_data),
    .st_push(st_push), .st_pop(st_pop), .st_data_in(st_data_in), .st_data_out(st_data_out),
    .st_full(st_full), .st_empty(st_empty),
    .result(result), .result_valid(result_valid), .result_ready(result_ready),
    .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  assign st_full  = sp == DEPTH;
  assign st_empty = sp == 0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sp          <= 0;
      st_data_out <= '0;
    end else if (st_push && sp < DEPTH) begin
      mem[sp] <= st_data_in;
      sp      <= sp + 1;
    end else if (st_pop && sp > 0) begin
      st_data_out <= mem[sp-1];
      sp          <= sp - 1;
    end
  end

  always @(posedge clk) begin
    if (rstn && st_push) pushes++;
    if (rstn && st_pop) pops++;
    if (rstn && ((st_push && st_pop) || (st_push && sp == DEPTH) || (st_pop && sp == 0))) bad++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic tok_t num(input logic [7:0] v);
    tok_t t;
    t.is_op = 1'b0;
    t.d     = v;
    return t;
  endfunction

  function automatic tok_t opr(input logic [1:0] o);
    tok_t t;
    t.is_op = 1'b1;
    t.d     = {6'($urandom), o};
    return t;
  endfunction

  // plain RPN semantics: what error (if any) and which token stops the expression
  function automatic void model(output logic [1:0] e, output logic [7:0] r, output int stop);
    logic [7:0] st[$];
    logic [7:0] a, b;
    e = 2'd0;
    r = '0;
    stop = q.size() - 1;
    foreach (q[i]) begin
      if (!q[i].is_op) begin
        if (st.size() == DEPTH) begin e = 2'd1; stop = i; return; end
        st.push_back(q[i].d);
      end else begin
        if (q[i].d[1:0] == 2'd3 || (q[i].d[1:0] == 2'd2 && !MUL_EN)) begin e = 2'd3; stop = i; return; end
        if (st.size() < 2) begin e = 2'd2; stop = i; return; end
        b = st.pop_back();
        a = st.pop_back();
        case (q[i].d[1:0])
          2'd0:    a = a + b;
          2'd1:    a = a - b;
          default: a = a * b;
        endcase
        st.push_back(a);
      end
      if (i == q.size() - 1) begin
        if (st.size() != 1) begin e = 2'd3; stop = i; return; end
        r = st[0];
      end
    end
  endfunction

  task automatic send(input tok_t t, input bit last);
    int n = 0;
    while (!token_ready && n < 100) begin @(negedge clk); n++; end
    if (n == 100) check("send_ready", token_ready, 1);
    token_valid = 1'b1;
    token_is_op = t.is_op;
    token_data  = t.d;
    token_last  = last;
    @(negedge clk);
    token_valid = 1'b0;
    token_last  = 1'b0;
  endtask

  task automatic run_expr(input logic [1:0] ee, input logic [7:0] er, input int stop);
    int n = 0;
    for (int i = 0; i <= stop; i++) send(q[i], i == q.size() - 1);
    while (!result_valid && err == 2'd0 && n < 200) begin @(negedge clk); n++; end
    check("finished", result_valid || err != 2'd0, 1);
    check("err", err, ee);
    if (result_valid) begin
      check("result", result, er);
      check("ready_in_done", token_ready, 0);
      repeat ($urandom_range(1, 3)) @(negedge clk);
      check("hold", {result_valid, result}, {1'b1, er});
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      check("released", {result_valid, token_ready}, 2'b01);
    end else begin
      n = 0;
      while (sp != 0 && n < 50) begin @(negedge clk); n++; end
      repeat (3) @(negedge clk);
      check("err_held", {err, token_ready, sp == 0}, {ee, 1'b0, 1'b1});
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("err_clr", {err, token_ready}, 3'b001);
    end
  endtask

  initial begin
    int p0, u0, stop, d, len, mode;
    logic [1:0] ee;
    logic [7:0] er;
    tok_t t;
    repeat (3) @(negedge clk);
    check("rst_async", {token_ready, st_push, st_pop, result_valid, err, result}, {4'b1000, 2'b00, 8'h00});
    rstn = 1'b1;
    @(negedge clk);
    check("rst_out", {token_ready, st_push, st_pop, result_valid, err, result}, {4'b1000, 2'b00, 8'h00});

    q = {num(3), num(4), opr(0)};           run_expr(2'd0, 8'd7, 2);
    q = {num(2), num(7), opr(1)};           run_expr(2'd0, 8'hFB, 2);
    q = {num(200), num(100), opr(0)};       run_expr(2'd0, 8'd44, 2);
    q = {num(5), num(1), num(2), opr(0), opr(2)};
    run_expr(MUL_EN ? 2'd0 : 2'd3, MUL_EN ? 8'd15 : 8'd0, 4);

    p0 = pops;
    q = {num(9), opr(0)};
    run_expr(2'd2, 8'd0, 1);
    check("unf_pops", pops - p0, 1);

    q.delete();
    for (int i = 0; i <= DEPTH; i++) q.push_back(num(8'(i + 1)));
    p0 = pops;
    u0 = pushes;
    run_expr(2'd1, 8'd0, DEPTH);
    check("ovf_pushes", pushes - u0, DEPTH);
    check("ovf_pops", pops - p0, DEPTH);

    q = {num(1), num(2)};
    run_expr(2'd3, 8'd0, 1);

    for (int k = 0; k < 60; k++) begin
      q.delete();
      mode = $urandom_range(0, 3);
      len  = $urandom_range(1, 10);
      d    = 0;
      for (int i = 0; i < len; i++) begin
        if (mode == 2) t.is_op = $urandom_range(0, 2) == 0;
        else t.is_op = !(d < 2 || ($urandom_range(0, 2) == 0 && d < DEPTH));
        t.d = $urandom_range(0, 1) ? 8'($urandom) : 8'($urandom_range(0, 5));
        if (t.is_op) t = opr(mode == 3 ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, MUL_EN ? 2 : 1)));
        d = t.is_op ? d - 1 : d + 1;
        q.push_back(t);
      end
      if (mode < 2) while (d > 1) begin q.push_back(opr(2'($urandom_range(0, MUL_EN ? 2 : 1)))); d--; end
      model(ee, er, stop);
      run_expr(ee, er, stop);
    end

    q = {num(3), num(4), opr(0)};
    run_expr(2'd0, 8'd7, 2);
    q = {num(5), num(6), opr(0)};
    send(q[0], 1'b0);
    send(q[1], 1'b0);
    send(q[2], 1'b1);
    check("getb_pop", {st_pop, token_ready}, 2'b10);
    rstn = 1'b0;
    #1;
    check("rst_mid", {token_ready, st_push, st_pop, result_valid, err, result}, {4'b1000, 2'b00, 8'h00});
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    q = {num(10), num(3), opr(1)};
    run_expr(2'd0, 8'd7, 2);

    check("stack_protocol", bad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
